// File: rtl/subservient_pkg.sv
// Shared constants for the SERV debug bridge: FSM encoding, CSR word indices,
// CTRL bit positions and the data word returned on a timed-out forward access.
package subservient_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_STATUS = 2'd1;
  localparam logic [1:0] CSR_TXN    = 2'd2;
  localparam logic [1:0] CSR_RSVD   = 2'd3;

  localparam int CTRL_DBG_MODE = 0;
  localparam int CTRL_CORE_RST = 1;

  localparam logic [31:0] DBG_TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/subservient_dbg_timer.sv
// Wait counter for a forwarded debug access; restarts on FWD entry and
// flags expiry once it has counted up to TIMEOUT.
module subservient_dbg_timer #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LP_TIMEOUT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] r_cnt;

  assign o_expired = (r_cnt == LP_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/subservient_dbg_bridge.sv
// Management-bus Wishbone slave in front of the SERV SoC: forwards a window to the
// SoC debug port with a bounded wait, and owns debug-mode/core-reset plus status CSRs.
module subservient_dbg_bridge
  import subservient_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          WIN_AW   = 24,
  parameter int          TIMEOUT  = 255,
  parameter int          TO_W     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        o_dbg_mode,
  output logic        o_core_rst,
  output logic [31:0] o_dbg_adr,
  output logic [31:0] o_dbg_dat,
  output logic [3:0]  o_dbg_sel,
  output logic        o_dbg_we,
  output logic        o_dbg_stb,
  input  logic [31:0] i_dbg_rdt,
  input  logic        i_dbg_ack
);

  logic [1:0]  r_state;
  logic        r_to_flag;
  logic [7:0]  r_to_cnt;
  logic [7:0]  r_err_cnt;
  logic [31:0] r_txn;
  // CSR write captured at request time, committed when leaving ACK
  logic        r_csr_wr;
  logic [1:0]  r_csr_idx;
  logic [1:0]  r_csr_wdat;
  logic        r_csr_wsel0;

  logic        w_hit;
  logic        w_is_csr;
  logic        w_fwd_start;
  logic        w_expired;
  logic        w_to_inc;
  logic        w_err_inc;
  logic        w_txn_inc;
  logic        w_w1c;
  logic [31:0] w_csr_rdata;

  assign w_hit    = wbs_cyc_i && wbs_stb_i &&
                    (wbs_adr_i[31:WIN_AW+1] == BASE_ADR[31:WIN_AW+1]);
  assign w_is_csr = wbs_adr_i[WIN_AW];

  assign w_fwd_start = (r_state == ST_IDLE) && w_hit && !w_is_csr && o_dbg_mode;
  assign w_err_inc   = (r_state == ST_IDLE) && w_hit && !w_is_csr && !o_dbg_mode;
  assign w_txn_inc   = (r_state == ST_FWD) && i_dbg_ack;
  assign w_to_inc    = (r_state == ST_FWD) && !i_dbg_ack && w_expired;
  assign w_w1c       = (r_state == ST_ACK) && r_csr_wr &&
                       (r_csr_idx == CSR_STATUS) && r_csr_wdat[0];

  always_comb begin
    w_csr_rdata = 32'h0;
    case (wbs_adr_i[3:2])
      CSR_CTRL:   w_csr_rdata = {30'h0, o_core_rst, o_dbg_mode};
      CSR_STATUS: w_csr_rdata = {8'h0, r_err_cnt, r_to_cnt, 7'h0, r_to_flag};
      CSR_TXN:    w_csr_rdata = r_txn;
      default:    w_csr_rdata = 32'h0;
    endcase
  end

  subservient_dbg_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .i_clr     (w_fwd_start),
    .i_en      (r_state == ST_FWD),
    .o_expired (w_expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= ST_IDLE;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= 32'h0;
      o_dbg_stb   <= 1'b0;
      o_dbg_we    <= 1'b0;
      o_dbg_adr   <= 32'h0;
      o_dbg_dat   <= 32'h0;
      o_dbg_sel   <= 4'h0;
      o_dbg_mode  <= 1'b1;
      o_core_rst  <= 1'b1;
      r_csr_wr    <= 1'b0;
      r_csr_idx   <= 2'h0;
      r_csr_wdat  <= 2'h0;
      r_csr_wsel0 <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          wbs_ack_o <= 1'b0;
          r_csr_wr  <= 1'b0;
          if (w_hit) begin
            if (w_is_csr) begin
              r_state     <= ST_ACK;
              wbs_ack_o   <= 1'b1;
              wbs_dat_o   <= w_csr_rdata;
              r_csr_wr    <= wbs_we_i;
              r_csr_idx   <= wbs_adr_i[3:2];
              r_csr_wdat  <= wbs_dat_i[1:0];
              r_csr_wsel0 <= wbs_sel_i[0];
            end else if (o_dbg_mode) begin
              r_state   <= ST_FWD;
              o_dbg_adr <= 32'(wbs_adr_i[WIN_AW-1:0]);
              o_dbg_dat <= wbs_dat_i;
              o_dbg_sel <= wbs_sel_i;
              o_dbg_we  <= wbs_we_i;
              o_dbg_stb <= 1'b1;
            end else begin
              // SRAM belongs to the core: drop writes, reads return zero
              r_state   <= ST_ACK;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= 32'h0;
            end
          end
        end
        ST_FWD: begin
          if (i_dbg_ack) begin
            r_state   <= ST_ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= i_dbg_rdt;
            o_dbg_stb <= 1'b0;
          end else if (w_expired) begin
            r_state   <= ST_ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= DBG_TIMEOUT_DATA;
            o_dbg_stb <= 1'b0;
          end
        end
        ST_ACK: begin
          r_state   <= ST_IDLE;
          wbs_ack_o <= 1'b0;
          r_csr_wr  <= 1'b0;
          if (r_csr_wr && (r_csr_idx == CSR_CTRL) && r_csr_wsel0) begin
            o_dbg_mode <= r_csr_wdat[CTRL_DBG_MODE];
            o_core_rst <= r_csr_wdat[CTRL_CORE_RST];
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          wbs_ack_o <= 1'b0;
          o_dbg_stb <= 1'b0;
        end
      endcase
    end
  end

  // Status counters: a W1C clear is applied first, then any same-cycle increment
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_to_flag <= 1'b0;
      r_to_cnt  <= 8'h0;
      r_err_cnt <= 8'h0;
      r_txn     <= 32'h0;
    end else begin
      r_to_flag <= w_to_inc | (r_to_flag & ~w_w1c);
      r_to_cnt  <= sat_inc8(w_w1c ? 8'h0 : r_to_cnt, w_to_inc);
      r_err_cnt <= sat_inc8(r_err_cnt, w_err_inc);
      if (w_txn_inc) r_txn <= r_txn + 32'd1;
    end
  end

endmodule

// File: tb/tb_subservient_dbg_bridge.sv
// Directed bench for the debug bridge: CSR access, forwarding, timeout,
// debug-mode-off errors, address misses and reset in the middle of a forward.
module tb_subservient_dbg_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        dbg_mode, core_rst, dbg_we, dbg_stb;
  logic [31:0] dbg_adr, dbg_dat;
  logic [3:0]  dbg_sel;
  logic [31:0] dbg_rdt = 32'h0;
  logic        dbg_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;
  logic [31:0] r_data;
  int          ack_cyc, stb_cyc;

  always #5 clk = ~clk;

  subservient_dbg_bridge dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .o_dbg_mode (dbg_mode),
    .o_core_rst (core_rst),
    .o_dbg_adr  (dbg_adr),
    .o_dbg_dat  (dbg_dat),
    .o_dbg_sel  (dbg_sel),
    .o_dbg_we   (dbg_we),
    .o_dbg_stb  (dbg_stb),
    .i_dbg_rdt  (dbg_rdt),
    .i_dbg_ack  (dbg_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // One Wishbone access. The debug-side model acks in the lat-th cycle of o_dbg_stb
  // (lat=0: never). ack_cyc is the cycle count from the sampling edge, -1 if none.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, input int lat, input logic [31:0] rdt, input int max_cyc);
    @(negedge clk);
    adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    ack_cyc = -1; stb_cyc = 0; r_data = 32'h0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      dbg_ack = 1'b0;
      if (dbg_stb) begin
        stb_cyc++;
        if (stb_cyc == 1) begin
          cap_adr = dbg_adr; cap_dat = dbg_dat; cap_sel = dbg_sel; cap_we = dbg_we;
        end
        if (lat > 0 && stb_cyc == lat) begin
          dbg_ack = 1'b1;
          dbg_rdt = rdt;
        end
      end
      if (ack) begin
        ack_cyc = c;
        r_data  = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; dbg_ack = 1'b0;
  endtask

  task automatic csr_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    xfer(a, 32'h0, 4'hF, 1'b0, 0, 32'h0, 10);
    chk({tag, "_lat"}, 32'(ack_cyc), 32'd1);
    chk(tag, r_data, exp);
  endtask

  task automatic csr_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    xfer(a, d, s, 1'b1, 0, 32'h0, 10);
    chk("csr_wr_lat", 32'(ack_cyc), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_stb", {31'h0, dbg_stb}, 32'h0);
    chk("rst_adr", dbg_adr, 32'h0);
    chk("rst_mode", {30'h0, core_rst, dbg_mode}, 32'h3);
    rst_n = 1'b1;

    csr_rd(32'h3100_0000, 32'h3, "ctrl_rst");
    chk("mode_core_rst", {30'h0, core_rst, dbg_mode}, 32'h3);

    // forwarded write acked after three strobe cycles
    xfer(32'h3000_0040, 32'h1234_5678, 4'hF, 1'b1, 3, 32'h0, 20);
    chk("fw_adr", cap_adr, 32'h40);
    chk("fw_dat", cap_dat, 32'h1234_5678);
    chk("fw_sel", {28'h0, cap_sel}, 32'hF);
    chk("fw_we", {31'h0, cap_we}, 32'h1);
    chk("fw_stb_cyc", 32'(stb_cyc), 32'd3);
    chk("fw_ack_cyc", 32'(ack_cyc), 32'd4);
    csr_rd(32'h3100_0008, 32'h1, "txn1");

    // forwarded read returns debug data
    xfer(32'h3000_0080, 32'h0, 4'h3, 1'b0, 2, 32'hCAFE_F00D, 20);
    chk("fr_adr", cap_adr, 32'h80);
    chk("fr_we", {31'h0, cap_we}, 32'h0);
    chk("fr_sel", {28'h0, cap_sel}, 32'h3);
    chk("fr_ack_cyc", 32'(ack_cyc), 32'd3);
    chk("fr_data", r_data, 32'hCAFE_F00D);
    csr_rd(32'h3100_0008, 32'h2, "txn2");

    // debug side never acks
    xfer(32'h3000_0044, 32'h0, 4'hF, 1'b0, 0, 32'h0, 400);
    chk("to_ack_cyc", 32'(ack_cyc), 32'd257);
    chk("to_stb_cyc", 32'(stb_cyc), 32'd256);
    chk("to_data", r_data, 32'hDEAD_BEEF);
    csr_rd(32'h3100_0004, 32'h0000_0101, "status_to");
    csr_wr(32'h3100_0004, 32'h1, 4'hF);
    csr_rd(32'h3100_0004, 32'h0, "status_w1c");
    csr_rd(32'h3100_000C, 32'h0, "rsvd");

    // debug mode off: forward hit is refused locally
    xfer(32'h3100_0000, 32'h0, 4'hF, 1'b1, 0, 32'h0, 10);
    chk("ctrl0_lat", 32'(ack_cyc), 32'd1);
    chk("mode_in_ack", {30'h0, core_rst, dbg_mode}, 32'h3);
    @(negedge clk);
    chk("mode_after", {30'h0, core_rst, dbg_mode}, 32'h0);
    xfer(32'h3000_0000, 32'h0, 4'hF, 1'b0, 1, 32'h5555_5555, 10);
    chk("off_ack_cyc", 32'(ack_cyc), 32'd1);
    chk("off_data", r_data, 32'h0);
    chk("off_stb", 32'(stb_cyc), 32'd0);
    csr_rd(32'h3100_0004, 32'h0001_0000, "err_cnt");

    // CTRL ignores writes without sel[0]
    csr_wr(32'h3100_0000, 32'h3, 4'hE);
    csr_rd(32'h3100_0000, 32'h0, "ctrl_nosel");
    csr_wr(32'h3100_0000, 32'h1, 4'h1);
    csr_rd(32'h3100_0000, 32'h1, "ctrl_mode1");

    // stray debug ack in IDLE is ignored
    @(negedge clk); dbg_ack = 1'b1;
    @(negedge clk); dbg_ack = 1'b0;
    chk("stray_ack", {31'h0, ack}, 32'h0);

    // miss outside the window
    xfer(32'h2000_0000, 32'h0, 4'hF, 1'b0, 1, 32'h0, 300);
    chk("miss_ack", 32'(ack_cyc), 32'hFFFF_FFFF);
    chk("miss_stb", 32'(stb_cyc), 32'd0);

    // reset asserted while a forward is pending
    @(negedge clk);
    adr = 32'h3000_0010; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_stb", {31'h0, dbg_stb}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_fwd_stb", {31'h0, dbg_stb}, 32'h0);
    chk("rst_fwd_ack", {31'h0, ack}, 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("rst_fwd_ack2", {31'h0, ack}, 32'h0);
    rst_n = 1'b1;
    csr_rd(32'h3100_0000, 32'h3, "ctrl_after_rst");
    csr_rd(32'h3100_0008, 32'h0, "txn_after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
